shift_rows: RTL and testbench



---
 rtl/aes_pkg.sv | 39 +++
 rtl/shift_rows_perm.sv | 19 +
 rtl/shift_rows.sv | 39 +++
 tb/tb_shift_rows.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, geometry constants and the ShiftRows / InvShiftRows byte permutations.
// Used by the round datapath and by the key-schedule benches.
package aes_pkg;

   localparam int NB      = 4;
   localparam int NR_ROWS = 4;

   typedef logic [127:0] state_t;
   typedef logic [7:0]   byte_t;

   // Byte 0 is the MSB; state element s[r][c] lives in byte 4c+r.
   function automatic byte_t get_byte(input state_t s, input int k);
      return s[127-8*k -: 8];
   endfunction

   function automatic state_t shift_rows_f(input state_t s);
      state_t r;
      // NOTE: blocking assignments are correct here: r is a local temporary, not state.
      r = '0;
      for (int c = 0; c < NB; c++) begin
         for (int row = 0; row < NR_ROWS; row++) begin
            r[127-8*(NR_ROWS*c+row) -: 8] = get_byte(s, NR_ROWS*((c+row)%NB) + row);
         end
      end
      return r;
   endfunction

   function automatic state_t inv_shift_rows_f(input state_t s);
      state_t r;
      r = '0;
      for (int c = 0; c < NB; c++) begin
         for (int row = 0; row < NR_ROWS; row++) begin
            r[127-8*(NR_ROWS*c+row) -: 8] = get_byte(s, NR_ROWS*((c+NB-row)%NB) + row);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational 16-byte ShiftRows crossbar; INVERSE=1 selects InvShiftRows.
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  state_t in,
   output state_t out
);

   generate
      if (INVERSE) begin : g_inv
         assign out = inv_shift_rows_f(in);
      end else begin : g_fwd
         assign out = shift_rows_f(in);
      end
   endgenerate

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows stage. Combinational by default; defining SHIFT_ROWS_REG_EN adds a
// 128-bit output register (1-cycle latency, synchronous active-high reset to 0).
module shift_rows
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] in,
   output logic [127:0] out
);

   state_t perm;

   shift_rows_perm #(.INVERSE(INVERSE)) u_perm (
      .in  (in),
      .out (perm)
   );

`ifdef SHIFT_ROWS_REG_EN
   state_t out_q;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= perm;
   end

   assign out = out_q;
`else
   // Clock and reset are kept on the port list so both builds share one footprint.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   assign out = perm;
`endif

endmodule

// File: tb/tb_shift_rows.sv
// Self-checking bench for shift_rows: forward, inverse and chained round-trip instances,
// scoreboard queue of expectations; covers both the default and SHIFT_ROWS_REG_EN builds.
module tb_shift_rows;
   import aes_pkg::*;

   typedef struct {
      string  name;
      state_t exp_fwd;
      state_t exp_inv;
      state_t exp_rt;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t in_fwd = '0;
   state_t in_inv = '0;
   state_t out_fwd, out_inv, out_rt;
   exp_t   sb[$];
   int     n_run  = 0;
   int     n_fail = 0;

   always #5 clk = ~clk;

   shift_rows #(.INVERSE(1'b0)) dut_fwd (.clk(clk), .rst(rst), .in(in_fwd),  .out(out_fwd));
   shift_rows #(.INVERSE(1'b1)) dut_inv (.clk(clk), .rst(rst), .in(in_inv),  .out(out_inv));
   shift_rows #(.INVERSE(1'b1)) dut_rt  (.clk(clk), .rst(rst), .in(out_fwd), .out(out_rt));

   // Reference: output byte k takes input byte (k + 4*row) mod 16 forward, (k - 4*row) mod 16 inverse.
   function automatic state_t ref_perm(input state_t s, input bit inv);
      state_t r;
      int     src;
      for (int k = 0; k < 16; k++) begin
         src = inv ? (k + 12*(k%4)) % 16 : (k + 4*(k%4)) % 16;
         r[127-8*k -: 8] = s[127-8*src -: 8];
      end
      return r;
   endfunction

   task automatic settle();
`ifdef SHIFT_ROWS_REG_EN
      repeat (2) @(posedge clk);
      #1;
`else
      #20;
`endif
   endtask

   task automatic apply_vec(input string name, input state_t vf, input state_t ef,
                            input state_t vi, input state_t ei);
      exp_t e;
      in_fwd = vf;
      in_inv = vi;
      sb.push_back('{name: name, exp_fwd: ef, exp_inv: ei, exp_rt: vf});
      settle();
      e = sb.pop_front();
      n_run++;
      if (out_fwd !== e.exp_fwd) begin
         n_fail++;
         $display("FAIL %s_fwd: got %h expected %h", e.name, out_fwd, e.exp_fwd);
      end
      n_run++;
      if (out_inv !== e.exp_inv) begin
         n_fail++;
         $display("FAIL %s_inv: got %h expected %h", e.name, out_inv, e.exp_inv);
      end
      n_run++;
      if (out_rt !== e.exp_rt) begin
         n_fail++;
         $display("FAIL %s_roundtrip: got %h expected %h", e.name, out_rt, e.exp_rt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_fwd = 128'h636363634c4c4c4cdbdbdbdb99999999;
      in_inv = 128'h634cdb994cdb9963db99634c99634cdb;
`ifdef SHIFT_ROWS_REG_EN
      repeat (2) @(posedge clk);
      #1;
      n_run++;
      if (out_fwd !== '0) begin
         n_fail++;
         $display("FAIL reset_fwd: got %h expected %h", out_fwd, 128'h0);
      end
      n_run++;
      if (out_inv !== '0) begin
         n_fail++;
         $display("FAIL reset_inv: got %h expected %h", out_inv, 128'h0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_run++;
      if (out_fwd !== 128'h634cdb994cdb9963db99634c99634cdb) begin
         n_fail++;
         $display("FAIL first_after_reset: got %h expected %h", out_fwd,
                  128'h634cdb994cdb9963db99634c99634cdb);
      end
`else
      // Combinational build: reset must have no effect on the output.
      #20;
      n_run++;
      if (out_fwd !== 128'h634cdb994cdb9963db99634c99634cdb) begin
         n_fail++;
         $display("FAIL reset_ignored_fwd: got %h expected %h", out_fwd,
                  128'h634cdb994cdb9963db99634c99634cdb);
      end
      n_run++;
      if (out_inv !== 128'h636363634c4c4c4cdbdbdbdb99999999) begin
         n_fail++;
         $display("FAIL reset_ignored_inv: got %h expected %h", out_inv,
                  128'h636363634c4c4c4cdbdbdbdb99999999);
      end
      rst = 1'b0;
`endif
   endtask

   task automatic test_vectors();
      apply_vec("spec",
                128'h636363634c4c4c4cdbdbdbdb99999999, 128'h634cdb994cdb9963db99634c99634cdb,
                128'h634cdb994cdb9963db99634c99634cdb, 128'h636363634c4c4c4cdbdbdbdb99999999);
      apply_vec("fips",
                128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5,
                128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230);
      apply_vec("counting",
                128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b,
                128'h00050a0f04090e03080d02070c01060b, 128'h000102030405060708090a0b0c0d0e0f);
      apply_vec("row0",
                128'hff000000ff000000ff000000ff000000, 128'hff000000ff000000ff000000ff000000,
                128'hff000000ff000000ff000000ff000000, 128'hff000000ff000000ff000000ff000000);
      apply_vec("zero", '0, '0, '0, '0);
   endtask

   task automatic test_x_prop();
      state_t v;
      v = 128'h000102030405060708090a0b0c0d0e0f;
      v[87:80] = 8'hxx;  // byte 5 unknown
      apply_vec("xprop", v, ref_perm(v, 1'b0), v, ref_perm(v, 1'b1));
   endtask

   task automatic test_back_to_back();
      exp_t   e;
      state_t v;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         v = {$urandom, $urandom, $urandom, $urandom};
         in_fwd = v;
         in_inv = v;
         sb.push_back('{name: "b2b", exp_fwd: ref_perm(v, 1'b0), exp_inv: ref_perm(v, 1'b1),
                        exp_rt: v});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_run++;
         if (out_fwd !== e.exp_fwd) begin
            n_fail++;
            $display("FAIL %s_fwd[%0d]: got %h expected %h", e.name, i, out_fwd, e.exp_fwd);
         end
         n_run++;
         if (out_inv !== e.exp_inv) begin
            n_fail++;
            $display("FAIL %s_inv[%0d]: got %h expected %h", e.name, i, out_inv, e.exp_inv);
         end
      end
   endtask

   task automatic test_mid_reset();
      state_t v;
      v = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      in_fwd = v;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_run++;
`ifdef SHIFT_ROWS_REG_EN
      if (out_fwd !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got %h expected %h", out_fwd, 128'h0);
      end
`else
      if (out_fwd !== ref_perm(v, 1'b0)) begin
         n_fail++;
         $display("FAIL mid_reset_ignored: got %h expected %h", out_fwd, ref_perm(v, 1'b0));
      end
`endif
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_x_prop();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
